// File: rtl/peak_sync.sv
// peak_sync: periodic correlation-peak synchroniser.
// Watches a stream of unsigned correlation values, finds peaks at or above
// THRESH, confirms LOCK_N consecutive peaks spaced PERIOD clocks apart, then
// tracks the expected peak position and drops lock after LOSS_N consecutive
// missing peaks.
// Optional build macro: PEAK_SYNC_STATS_EN adds the saturating counters
// peak_cnt (hit edges) and loss_cnt (LOCKED -> SEARCH transitions).
module peak_sync #(
    parameter int PERIOD = 31,
    parameter int THRESH = 56,
    parameter int LOCK_N = 3,
    parameter int LOSS_N = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  data,
    output logic        peak,
    output logic        sync,
    output logic        locked,
    output logic [4:0]  phase,
    output logic [1:0]  state
`ifdef PEAK_SYNC_STATS_EN
    ,
    output logic [15:0] peak_cnt,
    output logic [15:0] loss_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    localparam logic [4:0] PHASE_LAST = 5'(PERIOD - 1);
    localparam logic [7:0] THRESH_V   = 8'(THRESH);
    localparam logic [3:0] LOCK_V     = 4'(LOCK_N);
    localparam logic [3:0] LOSS_V     = 4'(LOSS_N);

    state_t      r_state;
    logic [4:0]  r_phase;
    logic [3:0]  r_hits;
    logic [3:0]  r_miss;
    logic        r_peak;
    logic        r_sync;
    logic        r_locked;

    logic        w_hit;
    logic        w_exp;
    logic [4:0]  w_phase_inc;
    logic [3:0]  w_hits_inc;
    logic [3:0]  w_miss_inc;
    logic        w_loss;

    assign w_hit       = (data >= THRESH_V);
    assign w_exp       = (r_phase == PHASE_LAST);
    assign w_phase_inc = w_exp ? 5'd0 : r_phase + 5'd1;
    assign w_hits_inc  = r_hits + 4'd1;
    assign w_miss_inc  = r_miss + 4'd1;
    // The expected peak is missing for the LOSS_N-th time in a row.
    assign w_loss      = (r_state == ST_LOCKED) && w_exp && !w_hit && (w_miss_inc == LOSS_V);

    // Acquisition / tracking FSM with all outputs registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_SEARCH;
            r_phase  <= 5'd0;
            r_hits   <= 4'd0;
            r_miss   <= 4'd0;
            r_peak   <= 1'b0;
            r_sync   <= 1'b0;
            r_locked <= 1'b0;
        end else begin
            r_peak  <= w_hit;
            r_sync  <= 1'b0;
            r_phase <= w_phase_inc;
            case (r_state)
                ST_SEARCH: begin
                    if (w_hit) begin
                        r_state <= ST_VERIFY;
                        r_phase <= 5'd0;
                        r_hits  <= 4'd1;
                    end
                end
                ST_VERIFY: begin
                    if (w_hit && w_exp) begin
                        r_hits <= w_hits_inc;
                        if (w_hits_inc == LOCK_V) begin
                            r_state  <= ST_LOCKED;
                            r_locked <= 1'b1;
                            r_miss   <= 4'd0;
                        end
                    end else if (w_exp) begin
                        r_state <= ST_SEARCH;
                        r_hits  <= 4'd0;
                    end else if (w_hit) begin
                        // Off-period peak: it becomes the new reference.
                        r_phase <= 5'd0;
                        r_hits  <= 4'd1;
                    end
                end
                ST_LOCKED: begin
                    // Off-period peaks are ignored here; only the expected slot matters.
                    if (w_exp) begin
                        if (w_hit) begin
                            r_sync <= 1'b1;
                            r_miss <= 4'd0;
                        end else if (w_miss_inc == LOSS_V) begin
                            r_state  <= ST_SEARCH;
                            r_locked <= 1'b0;
                            r_hits   <= 4'd0;
                            r_miss   <= 4'd0;
                        end else begin
                            r_miss <= w_miss_inc;
                        end
                    end
                end
                default: begin
                    r_state  <= ST_SEARCH;
                    r_locked <= 1'b0;
                    r_hits   <= 4'd0;
                    r_miss   <= 4'd0;
                end
            endcase
        end
    end

    assign peak   = r_peak;
    assign sync   = r_sync;
    assign locked = r_locked;
    assign phase  = r_phase;
    assign state  = r_state;

`ifdef PEAK_SYNC_STATS_EN
    logic [15:0] r_peak_cnt;
    logic [15:0] r_loss_cnt;

    // Saturating event counters for peaks seen and locks lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_peak_cnt <= 16'd0;
            r_loss_cnt <= 16'd0;
        end else begin
            if (w_hit && (r_peak_cnt != 16'hFFFF)) begin
                r_peak_cnt <= r_peak_cnt + 16'd1;
            end
            if (w_loss && (r_loss_cnt != 16'hFFFF)) begin
                r_loss_cnt <= r_loss_cnt + 16'd1;
            end
        end
    end

    assign peak_cnt = r_peak_cnt;
    assign loss_cnt = r_loss_cnt;
`endif

endmodule

// File: tb/tb_peak_sync.sv
// tb_peak_sync: directed bench for peak_sync with default parameters
// (PERIOD 31, THRESH 56, LOCK_N 3, LOSS_N 2).
module tb_peak_sync;

    logic        clk;
    logic        rst;
    logic [7:0]  data;
    logic        peak;
    logic        sync;
    logic        locked;
    logic [4:0]  phase;
    logic [1:0]  state;
`ifdef PEAK_SYNC_STATS_EN
    logic [15:0] peak_cnt;
    logic [15:0] loss_cnt;
`endif

    int n_tests;
    int n_fail;

    peak_sync dut (
        .clk    (clk),
        .rst    (rst),
        .data   (data),
        .peak   (peak),
        .sync   (sync),
        .locked (locked),
        .phase  (phase),
        .state  (state)
`ifdef PEAK_SYNC_STATS_EN
        ,
        .peak_cnt (peak_cnt),
        .loss_cnt (loss_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one data sample, let one rising edge consume it, sample 1 ns later.
    task automatic step(input logic [7:0] d);
        data = d;
        @(posedge clk);
        #1;
    endtask

    // n clocks of background (non-peak) data.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(8'd20);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
        $display("[TB] %s observed %0d expected %0d", tag, obs, exp);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst  = 1'b1;
        data = 8'd62;
        // Reset dominates even with a hit present on the data bus.
        step(8'd62);
        step(8'd62);
        chk("rst_state",  32'(state),  0);
        chk("rst_phase",  32'(phase),  0);
        chk("rst_peak",   32'(peak),   0);
        chk("rst_locked", 32'(locked), 0);
        chk("rst_sync",   32'(sync),   0);
        rst = 1'b0;

        // SEARCH free-runs phase.
        step(8'd20);
        chk("search_phase", 32'(phase), 1);
        chk("search_peak",  32'(peak),  0);

        // First peak: VERIFY, phase reference, peak pulse.
        step(8'd62);
        chk("p1_state", 32'(state), 1);
        chk("p1_phase", 32'(phase), 0);
        chk("p1_peak",  32'(peak),  1);
        idle(30);
        chk("p1_wait_phase", 32'(phase), 30);
        chk("p1_wait_peak",  32'(peak),  0);

        // Second on-period peak: still verifying.
        step(8'd62);
        chk("p2_state",  32'(state),  1);
        chk("p2_locked", 32'(locked), 0);
        chk("p2_phase",  32'(phase),  0);

        // Third on-period peak: lock one clock later, no sync yet.
        idle(30);
        step(8'd62);
        chk("p3_locked", 32'(locked), 1);
        chk("p3_state",  32'(state),  2);
        chk("p3_sync",   32'(sync),   0);

        // Fourth peak while locked: sync pulse.
        idle(30);
        step(8'd62);
        chk("p4_sync", 32'(sync), 1);
        chk("p4_peak", 32'(peak), 1);

        // Extra off-period peak at phase 10: peak only, phase undisturbed.
        idle(10);
        chk("extra_pre_phase", 32'(phase), 10);
        step(8'd60);
        chk("extra_peak",   32'(peak),   1);
        chk("extra_sync",   32'(sync),   0);
        chk("extra_phase",  32'(phase),  11);
        chk("extra_locked", 32'(locked), 1);
        idle(19);
        step(8'd62);
        chk("p5_sync", 32'(sync), 1);

        // One missed peak: lock held, no sync.
        idle(30);
        step(8'd20);
        chk("miss1_locked", 32'(locked), 1);
        chk("miss1_sync",   32'(sync),   0);
        chk("miss1_phase",  32'(phase),  0);
        idle(30);
        step(8'd62);
        chk("restore_sync",   32'(sync),   1);
        chk("restore_locked", 32'(locked), 1);

        // Two consecutive misses: first holds (proves miss was cleared), second drops.
        idle(30);
        step(8'd20);
        chk("loss_a_locked", 32'(locked), 1);
        idle(30);
        step(8'd20);
        chk("loss_b_locked", 32'(locked), 0);
        chk("loss_b_state",  32'(state),  0);

        // Early second peak in VERIFY resyncs the reference.
        step(8'd62);
        chk("rs_first_state", 32'(state), 1);
        idle(19);
        step(8'd62);
        chk("rs_phase", 32'(phase), 0);
        chk("rs_state", 32'(state), 1);
        idle(30);
        step(8'd62);
        chk("rs_p2_locked", 32'(locked), 0);
        chk("rs_p2_state",  32'(state),  1);
        idle(30);
        step(8'd62);
        chk("rs_p3_locked", 32'(locked), 1);

`ifdef PEAK_SYNC_STATS_EN
        chk("stats_peak_cnt", 32'(peak_cnt), 11);
        chk("stats_loss_cnt", 32'(loss_cnt), 1);
`endif

        // One-clock reset while locked.
        idle(5);
        rst = 1'b1;
        step(8'd20);
        rst = 1'b0;
        chk("mrst_locked", 32'(locked), 0);
        chk("mrst_phase",  32'(phase),  0);
        chk("mrst_state",  32'(state),  0);
`ifdef PEAK_SYNC_STATS_EN
        chk("mrst_peak_cnt", 32'(peak_cnt), 0);
        chk("mrst_loss_cnt", 32'(loss_cnt), 0);
`endif
        // First post-reset edge behaves as SEARCH.
        step(8'd62);
        chk("post_rst_state", 32'(state), 1);

        // Missing second peak in VERIFY returns to SEARCH.
        idle(30);
        step(8'd20);
        chk("vmiss_state", 32'(state), 0);
        chk("vmiss_phase", 32'(phase), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/peak_sync.md
PEAK_SYNC -- requirements
Module: peak_sync

Interface
REQ-001 Parameter PERIOD, default 31, sequence period in clocks; legal range 2..32.
REQ-002 Parameter THRESH, default 56, peak threshold compared against data (unsigned, >=).
REQ-003 Parameter LOCK_N, default 3, consecutive on-period peaks needed to declare lock; legal range 2..15.
REQ-004 Parameter LOSS_N, default 2, consecutive missed expected peaks that drop lock; legal range 1..15.
REQ-005 clk  input  1  system clock; all logic on rising edge.
REQ-006 rst  input  1  reset; synchronous, active-high.
REQ-007 data  input  8  correlation value from the upstream decoder, one new value per clock, unsigned.
REQ-008 peak  output  1  registered pulse: previous-cycle data >= THRESH.
REQ-009 sync  output  1  registered pulse: expected-phase hit while LOCKED.
REQ-010 locked  output  1  high while FSM is LOCKED.
REQ-011 phase  output  5  position within the period, 0 = clock after the reference peak.
REQ-012 state  output  2  FSM state: 0 SEARCH, 1 VERIFY, 2 LOCKED.

Function
REQ-013 hit = (data >= THRESH) at a clock edge; exp = (phase == PERIOD-1) at that edge.
REQ-014 peak SHALL equal hit registered, latency 1 clock, in every state.
REQ-015 phase SHALL increment by 1 each clock, wrapping PERIOD-1 -> 0; phase SHALL load 0 on any resync event.
REQ-016 SEARCH: on hit -> VERIFY, phase <= 0, hits <= 1; otherwise stay, phase free-runs.
REQ-017 VERIFY: hit && exp -> hits+1; if hits+1 == LOCK_N -> LOCKED, miss <= 0; else stay VERIFY.
REQ-018 VERIFY: !hit && exp -> SEARCH, hits <= 0.
REQ-019 VERIFY: hit && !exp -> resync: stay VERIFY, phase <= 0, hits <= 1 (latest peak becomes reference).
REQ-020 LOCKED: hit && exp -> sync pulse next clock, miss <= 0.
REQ-021 LOCKED: !hit && exp -> miss+1; if miss+1 == LOSS_N -> SEARCH, locked low next clock, hits <= 0.
REQ-022 LOCKED: hit && !exp -> peak pulse only; no resync, no miss change, no sync.
REQ-023 locked, sync, state SHALL be registered and change in the clock after the deciding edge.
REQ-024 hits and miss counters SHALL be 4 bits and SHALL never exceed LOCK_N / LOSS_N.
REQ-025 No data-valid handshake; every clock's data sample is consumed.

Reset
REQ-026 While rst is high at a clock edge: state SEARCH, phase 0, hits 0, miss 0, peak 0, sync 0, locked 0, statistics counters 0.
REQ-027 rst mid-operation (any state) SHALL abandon lock immediately; first post-reset edge evaluates data as in SEARCH.

Configuration
REQ-028 Macro PEAK_SYNC_STATS_EN defined: extra outputs peak_cnt (16, output, count of hit edges) and loss_cnt (16, output, count of LOCKED -> SEARCH transitions), both saturating at 16'hFFFF.
REQ-029 Macro PEAK_SYNC_STATS_EN undefined: those ports and counters SHALL not exist; all other behaviour identical.

Verification
REQ-030 Defaults, data = 62 every 31st clock, else 20 -> peak pulse each 31 clocks; locked rises 1 clock after third peak; sync pulse 1 clock after each later peak.
REQ-031 Locked, omit one peak (data 20) -> locked stays 1, no sync that period; next peak restores, miss 0.
REQ-032 Locked, omit two consecutive peaks -> locked falls 1 clock after second expected edge, state 0.
REQ-033 VERIFY after first peak, second peak arrives at 20 clocks -> phase reloads 0, hits 1; lock needs two further on-period peaks.
REQ-034 Locked, extra data = 60 at phase 10 -> peak pulse, sync absent, phase unaffected, locked stays 1.
REQ-035 rst asserted one clock while LOCKED -> next clock locked 0, phase 0, state 0; with PEAK_SYNC_STATS_EN, peak_cnt and loss_cnt read 0.
